detector_sequencer: RTL and testbench

- Sequencer that feeds a serial-input sequence-detector FSM (single bit input `w`, Moore output `z`) from a parallel word.
- On `start`, it captures a WIDTH-bit word and pulses a clear to the detector. It then shifts the word out one bit per clock, LSB-first, on `det_w`.
- It counts detector hits on `det_z` and reports the result with a busy/done handshake.
- Sits between the register/control logic and the detector instance, which it owns exclusively.

---
 rtl/detector_sequencer.sv | 144 ++++++++++++++
 tb/tb_detector_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/detector_sequencer.sv
// rtl/detector_sequencer.sv - feeds a parallel word LSB-first into a serial Moore detector and counts its hits
// Optional macro DETSEQ_FIRSTPOS_EN adds the first_pos output.
`timescale 1ns/1ps
module detector_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [WIDTH-1:0]         data,
    input  logic                     det_z,
    output logic                     det_w,
    output logic                     det_clr,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         hit_count,
    output logic                     hit_any
`ifdef DETSEQ_FIRSTPOS_EN
    ,
    output logic [$clog2(WIDTH)-1:0] first_pos
`endif
);

    localparam int BC_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [BC_W-1:0]    bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sample;
    logic               last_bit;

`ifdef DETSEQ_FIRSTPOS_EN
    logic [BC_W-1:0]    fpos_q, fpos_d;
    logic [BC_W-1:0]    sample_idx;
`endif

    // Moore detector: z for bit k appears one cycle later, so sampling skips
    // the first SHIFT cycle and extends one cycle into DRAIN.
    assign sample   = ((state_q == S_SHIFT) && (bitcnt_q != '0)) || (state_q == S_DRAIN);
    assign last_bit = (bitcnt_q == BC_W'(WIDTH - 1));

`ifdef DETSEQ_FIRSTPOS_EN
    // Bit index that produced the z currently being sampled.
    assign sample_idx = (state_q == S_DRAIN) ? BC_W'(WIDTH - 1) : (bitcnt_q - BC_W'(1));
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: shift word, bit position, hit counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q  <= '0;
            bitcnt_q <= '0;
            cnt_q    <= '0;
`ifdef DETSEQ_FIRSTPOS_EN
            fpos_q   <= '1;
`endif
        end else begin
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            cnt_q    <= cnt_d;
`ifdef DETSEQ_FIRSTPOS_EN
            fpos_q   <= fpos_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLEAR;
            S_CLEAR: state_d = S_SHIFT;
            S_SHIFT: if (last_bit) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: capture on accepted start, shift, saturating hit count
    always_comb begin
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        cnt_d    = cnt_q;
`ifdef DETSEQ_FIRSTPOS_EN
        fpos_d   = fpos_q;
`endif
        if ((state_q == S_IDLE) && start) begin
            shreg_d  = data;
            bitcnt_d = '0;
            cnt_d    = '0;
`ifdef DETSEQ_FIRSTPOS_EN
            fpos_d   = '1;
`endif
        end
        if (state_q == S_SHIFT) begin
            shreg_d  = shreg_q >> 1;
            bitcnt_d = last_bit ? '0 : (bitcnt_q + BC_W'(1));
        end
        if (sample && det_z) begin
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
`ifdef DETSEQ_FIRSTPOS_EN
            // A zero count means no hit yet in this word.
            if (cnt_q == '0) begin
                fpos_d = sample_idx;
            end
`endif
        end
    end

    // Outputs decoded from state and registers only
    always_comb begin
        det_w     = (state_q == S_SHIFT) ? shreg_q[0] : 1'b0;
        det_clr   = (state_q == S_CLEAR);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        hit_count = cnt_q;
        hit_any   = (cnt_q != '0);
`ifdef DETSEQ_FIRSTPOS_EN
        first_pos = fpos_q;
`endif
    end

endmodule

// File: tb/tb_detector_sequencer.sv
// tb/tb_detector_sequencer.sv - self-checking bench for detector_sequencer with an echo detector model
`timescale 1ns/1ps
module tb_detector_sequencer;

    localparam int W  = 8;
    localparam int PW = $clog2(W);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, start;
    logic [W-1:0] data;
    logic         z_stub_en, z_stub_val;

    logic         echo4_q, echo3_q, det_z4, det_z3;
    logic         det_w4, det_clr4, busy4, done4, any4;
    logic         det_w3, det_clr3, busy3, done3, any3;
    logic [3:0]   cnt4;
    logic [2:0]   cnt3;
`ifdef DETSEQ_FIRSTPOS_EN
    logic [PW-1:0] fp4, fp3;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    detector_sequencer #(.WIDTH(W), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .data(data), .det_z(det_z4),
        .det_w(det_w4), .det_clr(det_clr4), .busy(busy4), .done(done4),
        .hit_count(cnt4), .hit_any(any4)
`ifdef DETSEQ_FIRSTPOS_EN
        , .first_pos(fp4)
`endif
    );

    detector_sequencer #(.WIDTH(W), .CNT_W(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .data(data), .det_z(det_z3),
        .det_w(det_w3), .det_clr(det_clr3), .busy(busy3), .done(done3),
        .hit_count(cnt3), .hit_any(any3)
`ifdef DETSEQ_FIRSTPOS_EN
        , .first_pos(fp3)
`endif
    );

    // Echo detector: z(t) = w(t-1), cleared by det_clr
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            echo4_q <= 1'b0;
            echo3_q <= 1'b0;
        end else begin
            echo4_q <= det_clr4 ? 1'b0 : det_w4;
            echo3_q <= det_clr3 ? 1'b0 : det_w3;
        end
    end
    assign det_z4 = z_stub_en ? z_stub_val : echo4_q;
    assign det_z3 = z_stub_en ? z_stub_val : echo3_q;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int popc(input logic [W-1:0] d);
        int n = 0;
        for (int i = 0; i < W; i++) n += int'(d[i]);
        return n;
    endfunction

    function automatic int sat(input int n, input int cw);
        int mx = (1 << cw) - 1;
        return (n > mx) ? mx : n;
    endfunction

    function automatic int first_set(input logic [W-1:0] d);
        for (int i = 0; i < W; i++) if (d[i]) return i;
        return (1 << PW) - 1;
    endfunction

    // One word from accepted start through the first IDLE cycle after DONE.
    task automatic run_word(input logic [W-1:0] d, input bit stub, input int e4, input int e3,
                            input int efp, input string tag);
        int  wbad = 0, clrbad = 0, donebad = 0, busybad = 0;
        logic exp_w;
        @(negedge clk);
        start = 1'b1;
        data  = d;
        z_stub_val = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= W + 3; k++) begin
            @(negedge clk);
            z_stub_val = stub && (k == 1 || k == 2 || k == W + 3);
            exp_w = (k >= 2 && k <= W + 1) ? d[k-2] : 1'b0;
            if (det_w4 !== exp_w || det_w3 !== exp_w) wbad++;
            if (det_clr4 !== (k == 1) || det_clr3 !== (k == 1)) clrbad++;
            if (done4 !== (k == W + 3) || done3 !== (k == W + 3)) donebad++;
            if (busy4 !== 1'b1 || busy3 !== 1'b1) busybad++;
            if (k == W + 3) begin
                check({tag, " hit_count cw4"}, 64'(cnt4), 64'(e4));
                check({tag, " hit_count cw3"}, 64'(cnt3), 64'(e3));
                check({tag, " hit_any"}, 64'(any4), 64'(e4 != 0));
`ifdef DETSEQ_FIRSTPOS_EN
                check({tag, " first_pos cw4"}, 64'(fp4), 64'(efp));
                check({tag, " first_pos cw3"}, 64'(fp3), 64'(efp));
`endif
            end
        end
        @(negedge clk);
        z_stub_val = 1'b0;
        check({tag, " det_w sequence errors"}, 64'(wbad), 64'd0);
        check({tag, " det_clr timing errors"}, 64'(clrbad), 64'd0);
        check({tag, " done timing errors"}, 64'(donebad), 64'd0);
        check({tag, " busy errors"}, 64'(busybad), 64'd0);
        check({tag, " idle busy"}, 64'(busy4), 64'd0);
        check({tag, " idle hold count"}, 64'(cnt4), 64'(e4));
`ifdef DETSEQ_FIRSTPOS_EN
        check({tag, " idle hold first_pos"}, 64'(fp4), 64'(efp));
`endif
    endtask

    typedef struct {
        logic [W-1:0] d;
        int           e4;
        int           e3;
        int           efp;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int clr_n, done_n, posbad, bad;
        logic [W-1:0] rd;

        tbl[0] = '{8'hB5, 5, 5, 0};
        tbl[1] = '{8'h00, 0, 0, 7};
        tbl[2] = '{8'hFF, 8, 7, 0};
        tbl[3] = '{8'h80, 1, 1, 7};
        tbl[4] = '{8'h03, 2, 2, 0};
        tbl[5] = '{8'h0F, 4, 4, 0};

        reset = 1'b0; start = 1'b0; data = '0;
        z_stub_en = 1'b0; z_stub_val = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy4), 64'd0);
        check("reset done", 64'(done4), 64'd0);
        check("reset det_w", 64'(det_w4), 64'd0);
        check("reset det_clr", 64'(det_clr4), 64'd0);
        check("reset hit_count", 64'(cnt4), 64'd0);
        check("reset hit_any", 64'(any4), 64'd0);
`ifdef DETSEQ_FIRSTPOS_EN
        check("reset first_pos", 64'(fp4), 64'((1 << PW) - 1));
`endif
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_word(tbl[i].d, 1'b0, tbl[i].e4, tbl[i].e3, tbl[i].efp, $sformatf("vec%0d", i));

        // start held high: one word every W+4 cycles, mid-word data change ignored
        clr_n = 0; done_n = 0; posbad = 0;
        @(negedge clk);
        start = 1'b1;
        data  = 8'h0F;
        @(posedge clk);
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (k == 5)  data = 8'hFF;
            if (k == 10) data = 8'h0F;
            if (k == 36) start = 1'b0;
            if (det_clr4) begin
                clr_n++;
                if ((k % 12) != 1) posbad++;
            end
            if (done4) begin
                done_n++;
                if ((k % 12) != 11) posbad++;
                check($sformatf("held start word result k=%0d", k), 64'(cnt4), 64'd4);
            end
        end
        check("held start det_clr count", 64'(clr_n), 64'd3);
        check("held start done count", 64'(done_n), 64'd3);
        check("held start pulse positions", 64'(posbad), 64'd0);
        repeat (2) @(negedge clk);

        // reset asserted in SHIFT cycle 5 aborts the word
        @(negedge clk);
        start = 1'b1;
        data  = 8'hB5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort busy", 64'(busy4), 64'd0);
        check("abort done", 64'(done4), 64'd0);
        check("abort hit_count", 64'(cnt4), 64'd0);
        check("abort det_w", 64'(det_w4), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bad = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done4 || det_clr4 || busy4) bad++;
        end
        check("abort no later activity", 64'(bad), 64'd0);
        run_word(8'h03, 1'b0, 2, 2, 0, "after abort");

        // det_z high only where it must be ignored
        z_stub_en = 1'b1;
        run_word(8'hFF, 1'b1, 0, 0, (1 << PW) - 1, "ignored z");
        z_stub_en = 1'b0;

        // randomized words against the popcount model
        for (int i = 0; i < 20; i++) begin
            rd = W'($urandom);
            run_word(rd, 1'b0, sat(popc(rd), 4), sat(popc(rd), 3), first_set(rd),
                     $sformatf("rand%0d d=%0h", i, rd));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
